// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter.
//   STATE_W : width of the arbiter state encoding
//   state_e : IDLE (no owner), BURST (owner transfers), GAP (one-cycle
//             separation after a burst)
package pkt_arb_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per source
//   ptr  : index of the previous winner; the scan starts at ptr+1
//   pick : one-hot winner (all zero when nothing is requesting)
//   idx  : index of the winner (0 when nothing is requesting)
//   any  : at least one request is present
// The request vector is rotated so that source ptr+1 lands at bit 0, the
// lowest set bit is found, and the offset is rotated back to a source index.
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   function automatic logic [IDX_W-1:0] wrap_idx(input int a);
      return IDX_W'(a % NUM_REQ);
   endfunction

   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   off;
   logic               found;

   always_comb begin
      rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = req[wrap_idx(int'(ptr) + 1 + i)];
      end

      found = 1'b0;
      off   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            off   = IDX_W'(i);
         end
      end

      idx  = found ? wrap_idx(int'(ptr) + 1 + int'(off)) : '0;
      pick = '0;
      if (found) pick[idx] = 1'b1;
   end

   assign any = |req;

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Round-robin scheduler sharing one packet checker among NUM_REQ sources.
// One source owns the checker bus for a burst of PKT_LEN words; accepted
// words are registered onto the checker input. Checker error pulses seen
// while a burst is owned (BURST or GAP) set a sticky flag for the owner.
//   clk, reset     : clock, synchronous active-low reset
//   req_valid      : per-source word valid
//   req_data       : source k at [k*BUS_SIZE +: BUS_SIZE]
//   req_ready      : per-source accept (combinational)
//   chk_error      : error output of the checker
//   bus_data_out   : registered word to the checker
//   bus_valid      : bus_data_out holds a new word this cycle
//   grant          : registered one-hot owner, or zero
//   err_flags      : sticky per-source error flags
//   state_control  : current state, for debug
module pkt_rr_arbiter
   import pkt_arb_pkg::*;
#(
   parameter int BUS_SIZE = 16,
   parameter int NUM_REQ  = 4,
   parameter int PKT_LEN  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*BUS_SIZE-1:0]  req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         chk_error,
   output logic [BUS_SIZE-1:0]          bus_data_out,
   output logic                         bus_valid,
   output logic [NUM_REQ-1:0]           grant,
   output logic [NUM_REQ-1:0]           err_flags,
   output logic [STATE_W-1:0]           state_control
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [BUS_SIZE-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;

   logic [NUM_REQ-1:0]  pick;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic [BUS_SIZE-1:0] owner_word;
   logic                xfer;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req  (req_valid),
      .ptr  (ptr_q),
      .pick (pick),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // rr_ptr is loaded with the winner at grant time, so while a burst is
   // owned it doubles as the owner index.
   always_comb begin
      owner_word = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ptr_q == IDX_W'(k)) owner_word = req_data[k*BUS_SIZE +: BUS_SIZE];
      end
   end

   assign req_ready = (state_q == ST_BURST) ? grant_q : '0;
   assign xfer      = |(req_valid & req_ready);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = err_q;
      beat_d  = beat_q;
      ptr_d   = ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick;
               ptr_d   = pick_idx;
               beat_d  = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               data_d  = owner_word;
               valid_d = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = ST_GAP;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            // Owner kept through GAP so a late checker error still lands on it.
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase

      if (chk_error && (state_q == ST_BURST || state_q == ST_GAP)) begin
         err_d[ptr_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= '0;
         beat_q  <= '0;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         beat_q  <= beat_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus_data_out  = data_q;
   assign bus_valid     = valid_q;
   assign grant         = grant_q;
   assign err_flags     = err_q;
   assign state_control = state_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
module tb_pkt_rr_arbiter;
   import pkt_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        chk_error;
   logic [15:0] bus_data_out;
   logic        bus_valid;
   logic [3:0]  grant;
   logic [3:0]  err_flags;
   logic [1:0]  state_control;

   logic [1:0]  vb;
   logic [31:0] db;
   logic [1:0]  rb;
   logic        chkb;
   logic [15:0] bdb;
   logic        bvb;
   logic [1:0]  gb;
   logic [1:0]  eb;
   logic [1:0]  sb;

   pkt_rr_arbiter #(.BUS_SIZE(16), .NUM_REQ(4), .PKT_LEN(4)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .chk_error(chk_error), .bus_data_out(bus_data_out),
      .bus_valid(bus_valid), .grant(grant), .err_flags(err_flags),
      .state_control(state_control)
   );

   pkt_rr_arbiter #(.BUS_SIZE(16), .NUM_REQ(2), .PKT_LEN(1)) u_dut_b (
      .clk(clk), .reset(reset), .req_valid(vb), .req_data(db),
      .req_ready(rb), .chk_error(chkb), .bus_data_out(bdb),
      .bus_valid(bvb), .grant(gb), .err_flags(eb),
      .state_control(sb)
   );

   int nvec = 0;
   int nerr = 0;
   int k;
   int cnt[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int s, input logic [15:0] w);
      req_data[s*16 +: 16] = w;
   endtask

   function automatic logic [15:0] word(input int s, input int c);
      return 16'hC000 + 16'(s * 256) + 16'(c);
   endfunction

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      chk_error = 1'b0;
      vb        = '0;
      db        = '0;
      chkb      = 1'b0;
      tick();
      tick();
      chk("rst state", 32'(state_control), 32'(ST_IDLE));
      chk("rst grant", 32'(grant), 0);
      chk("rst valid", 32'(bus_valid), 0);
      chk("rst data", 32'(bus_data_out), 0);
      chk("rst err", 32'(err_flags), 0);
      reset = 1'b1;

      // single source 1, words F001..F004
      req_valid = 4'b0010;
      put(1, 16'hF001);
      tick();
      chk("t1 grant", 32'(grant), 32'h2);
      chk("t1 ready", 32'(req_ready), 32'h2);
      for (int w = 1; w <= 4; w++) begin
         tick();
         chk("t1 valid", 32'(bus_valid), 1);
         chk("t1 data", 32'(bus_data_out), 32'(16'hF000 + 16'(w)));
         put(1, 16'hF000 + 16'(w + 1));
      end
      chk("t1 gap state", 32'(state_control), 32'(ST_GAP));
      chk("t1 gap ready", 32'(req_ready), 0);
      req_valid = '0;
      tick();
      chk("t1 idle state", 32'(state_control), 32'(ST_IDLE));
      chk("t1 idle grant", 32'(grant), 0);
      chk("t1 err", 32'(err_flags), 0);

      // all four sources continuously valid, from a fresh reset
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int s = 0; s < 4; s++) begin
         cnt[s] = 0;
         put(s, word(s, 0));
      end
      req_valid = 4'hF;
      for (int b = 0; b < 5; b++) begin
         k = b % 4;
         tick();
         chk("t2 grant", 32'(grant), 32'(1) << k);
         chk("t2 ready", 32'(req_ready), 32'(1) << k);
         chk("t2 gap valid", 32'(bus_valid), 0);
         for (int w = 0; w < 4; w++) begin
            tick();
            chk("t2 valid", 32'(bus_valid), 1);
            chk("t2 data", 32'(bus_data_out), 32'(word(k, cnt[k])));
            cnt[k]++;
            put(k, word(k, cnt[k]));
         end
         chk("t2 gap state", 32'(state_control), 32'(ST_GAP));
         tick();
         chk("t2 idle state", 32'(state_control), 32'(ST_IDLE));
         chk("t2 idle valid", 32'(bus_valid), 0);
         chk("t2 idle grant", 32'(grant), 0);
      end

      // owner 2 stalls for 3 cycles after word 2 while the others request
      req_valid = '0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req_valid = 4'b0100;
      put(2, 16'hD001);
      tick();
      chk("t3 grant", 32'(grant), 32'h4);
      tick();
      chk("t3 w1", 32'(bus_data_out), 32'hD001);
      put(2, 16'hD002);
      tick();
      chk("t3 w2", 32'(bus_data_out), 32'hD002);
      req_valid = 4'b1011;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t3 stall valid", 32'(bus_valid), 0);
         chk("t3 stall data", 32'(bus_data_out), 32'hD002);
         chk("t3 stall ready", 32'(req_ready), 32'h4);
         chk("t3 stall state", 32'(state_control), 32'(ST_BURST));
      end
      req_valid = 4'hF;
      put(2, 16'hD003);
      tick();
      chk("t3 w3", 32'(bus_data_out), 32'hD003);
      chk("t3 w3 state", 32'(state_control), 32'(ST_BURST));
      put(2, 16'hD004);
      tick();
      chk("t3 w4", 32'(bus_data_out), 32'hD004);
      chk("t3 end state", 32'(state_control), 32'(ST_GAP));
      chk("t3 gap ready", 32'(req_ready), 0);
      req_valid = '0;
      tick();
      chk("t3 idle", 32'(state_control), 32'(ST_IDLE));

      // error pulse in GAP after source 1's burst, then one in IDLE
      req_valid = 4'b0010;
      put(1, 16'hE001);
      tick();
      chk("t4 grant", 32'(grant), 32'h2);
      for (int w = 1; w <= 4; w++) begin
         tick();
         chk("t4 data", 32'(bus_data_out), 32'(16'hE000 + 16'(w)));
         put(1, 16'hE000 + 16'(w + 1));
      end
      chk("t4 gap state", 32'(state_control), 32'(ST_GAP));
      chk("t4 pre err", 32'(err_flags), 0);
      chk_error = 1'b1;
      req_valid = '0;
      tick();
      chk("t4 err gap", 32'(err_flags), 32'h2);
      chk("t4 idle", 32'(state_control), 32'(ST_IDLE));
      tick();
      chk("t4 err idle", 32'(err_flags), 32'h2);
      chk_error = 1'b0;

      // reset mid-burst at beat 2
      req_valid = 4'b0001;
      put(0, 16'hA001);
      tick();
      chk("t5 grant", 32'(grant), 32'h1);
      tick();
      chk("t5 w1", 32'(bus_data_out), 32'hA001);
      put(0, 16'hA002);
      tick();
      chk("t5 w2", 32'(bus_data_out), 32'hA002);
      reset = 1'b0;
      tick();
      chk("t5 rst grant", 32'(grant), 0);
      chk("t5 rst valid", 32'(bus_valid), 0);
      chk("t5 rst err", 32'(err_flags), 0);
      chk("t5 rst state", 32'(state_control), 32'(ST_IDLE));
      reset = 1'b1;
      req_valid = 4'hF;
      tick();
      chk("t5 first win", 32'(grant), 32'h1);
      req_valid = '0;
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // PKT_LEN=1, NUM_REQ=2: alternating single-word grants
      cnt[0] = 0;
      cnt[1] = 0;
      db[15:0]  = 16'hB000;
      db[31:16] = 16'hB100;
      vb = 2'b11;
      for (int g = 0; g < 3; g++) begin
         k = g % 2;
         tick();
         chk("t6 grant", 32'(gb), 32'(1) << k);
         chk("t6 ready", 32'(rb), 32'(1) << k);
         tick();
         chk("t6 valid", 32'(bvb), 1);
         chk("t6 data", 32'(bdb), 32'(16'hB000 + 16'(k * 256) + 16'(cnt[k])));
         cnt[k]++;
         db[k*16 +: 16] = 16'hB000 + 16'(k * 256) + 16'(cnt[k]);
         chk("t6 gap", 32'(sb), 32'(ST_GAP));
         tick();
         chk("t6 idle valid", 32'(bvb), 0);
         chk("t6 idle grant", 32'(gb), 0);
      end
      vb = '0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
